// File: rtl/axil_share_mem_bridge.sv
// AXI4-Lite slave -> share_memory requester port bridge (single-word accesses).
// Latency with immediate grant: bvalid 2 cycles after the AW+W handshake, rvalid 2 cycles after AR.
// Backpressure: one holding slot per AXI channel, ready low while full; grant wait bounded by TIMEOUT_CYCLES.
//
// Optional feature macro: AXIL_BRIDGE_STRB_CHECK_EN (reject partial-strobe writes with SLVERR).
// Ports: clk, rst (async, active-high); s_axil_aw*/w*/b*/ar*/r* AXI4-Lite slave;
//        axi_request/axi_we/axi_addr/axi_wdata out and axi_grant/axi_rdata in toward share_memory.
module axil_share_mem_bridge #(
   parameter int AXIL_ADDR_W    = 10,
   parameter int MEM_ADDR_W     = 8,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [AXIL_ADDR_W-1:0]  s_axil_awaddr,
   input  logic                    s_axil_awvalid,
   output logic                    s_axil_awready,
   input  logic [DATA_W-1:0]       s_axil_wdata,
   input  logic [DATA_W/8-1:0]     s_axil_wstrb,
   input  logic                    s_axil_wvalid,
   output logic                    s_axil_wready,
   output logic [1:0]              s_axil_bresp,
   output logic                    s_axil_bvalid,
   input  logic                    s_axil_bready,
   input  logic [AXIL_ADDR_W-1:0]  s_axil_araddr,
   input  logic                    s_axil_arvalid,
   output logic                    s_axil_arready,
   output logic [DATA_W-1:0]       s_axil_rdata,
   output logic [1:0]              s_axil_rresp,
   output logic                    s_axil_rvalid,
   input  logic                    s_axil_rready,
   output logic                    axi_request,
   output logic                    axi_we,
   output logic [MEM_ADDR_W-1:0]   axi_addr,
   output logic [DATA_W-1:0]       axi_wdata,
   input  logic [DATA_W-1:0]       axi_rdata,
   input  logic                    axi_grant
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_REQ  = 3'd1;
   localparam logic [2:0] S_WR_RESP = 3'd2;
   localparam logic [2:0] S_RD_REQ  = 3'd3;
   localparam logic [2:0] S_RD_WAIT = 3'd4;
   localparam logic [2:0] S_RD_RESP = 3'd5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   // Value of the wait counter on the last denied cycle before giving up.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]            state;
   logic                  aw_held, w_held, ar_held;
   logic [MEM_ADDR_W-1:0] aw_addr_q, ar_addr_q;
   logic [DATA_W-1:0]     w_data_q;
   logic [STRB_W-1:0]     w_strb_q;
   logic                  last_wr;   // 1: last transaction served was a write
   logic [CNT_W-1:0]      cnt;

   logic                  aw_fire, w_fire, ar_fire;
   logic                  wr_avail, rd_avail, pick_wr, pick_rd;
   logic [MEM_ADDR_W-1:0] cur_aw_addr, cur_ar_addr;
   logic [DATA_W-1:0]     cur_wdata;
   logic [STRB_W-1:0]     cur_wstrb;
   logic                  strb_bad;
   logic                  timeout_hit;
   logic                  unused_inputs;

   assign s_axil_awready = ~rst & ~aw_held;
   assign s_axil_wready  = ~rst & ~w_held;
   assign s_axil_arready = ~rst & ~ar_held;

   assign aw_fire = s_axil_awvalid & s_axil_awready;
   assign w_fire  = s_axil_wvalid  & s_axil_wready;
   assign ar_fire = s_axil_arvalid & s_axil_arready;

   // A channel counts as available in the cycle it handshakes, so IDLE can launch the
   // memory request on the same edge that captures the AXI beat.
   assign wr_avail = (aw_held | aw_fire) & (w_held | w_fire);
   assign rd_avail = ar_held | ar_fire;
   assign pick_wr  = wr_avail & (~rd_avail | ~last_wr);
   assign pick_rd  = rd_avail & ~pick_wr;

   assign cur_aw_addr = aw_held ? aw_addr_q : s_axil_awaddr[MEM_ADDR_W+1:2];
   assign cur_ar_addr = ar_held ? ar_addr_q : s_axil_araddr[MEM_ADDR_W+1:2];
   assign cur_wdata   = w_held  ? w_data_q  : s_axil_wdata;
   assign cur_wstrb   = w_held  ? w_strb_q  : s_axil_wstrb;

`ifdef AXIL_BRIDGE_STRB_CHECK_EN
   assign strb_bad = (cur_wstrb != {STRB_W{1'b1}});
`else
   assign strb_bad = 1'b0;
`endif

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

   // Byte-offset bits (and strobes when unchecked) carry no meaning here.
   assign unused_inputs = ^{s_axil_awaddr, s_axil_araddr, cur_wstrb};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         ar_held       <= 1'b0;
         aw_addr_q     <= '0;
         ar_addr_q     <= '0;
         w_data_q      <= '0;
         w_strb_q      <= '0;
         last_wr       <= 1'b0;
         cnt           <= '0;
         axi_request   <= 1'b0;
         axi_we        <= 1'b0;
         axi_addr      <= '0;
         axi_wdata     <= '0;
         s_axil_bvalid <= 1'b0;
         s_axil_bresp  <= RESP_OKAY;
         s_axil_rvalid <= 1'b0;
         s_axil_rresp  <= RESP_OKAY;
         s_axil_rdata  <= '0;
      end else begin
         // Capture first; state actions below may clear a flag on the same edge.
         if (aw_fire) begin
            aw_held   <= 1'b1;
            aw_addr_q <= s_axil_awaddr[MEM_ADDR_W+1:2];
         end
         if (w_fire) begin
            w_held   <= 1'b1;
            w_data_q <= s_axil_wdata;
            w_strb_q <= s_axil_wstrb;
         end
         if (ar_fire) begin
            ar_held   <= 1'b1;
            ar_addr_q <= s_axil_araddr[MEM_ADDR_W+1:2];
         end

         case (state)
            S_IDLE: begin
               if (pick_wr) begin
                  if (strb_bad) begin
                     state        <= S_WR_RESP;
                     s_axil_bresp <= RESP_SLVERR;
                     aw_held      <= 1'b0;
                     w_held       <= 1'b0;
                     last_wr      <= 1'b1;
                  end else begin
                     state       <= S_WR_REQ;
                     axi_request <= 1'b1;
                     axi_we      <= 1'b1;
                     axi_addr    <= cur_aw_addr;
                     axi_wdata   <= cur_wdata;
                     cnt         <= '0;
                  end
               end else if (pick_rd) begin
                  state       <= S_RD_REQ;
                  axi_request <= 1'b1;
                  axi_we      <= 1'b0;
                  axi_addr    <= cur_ar_addr;
                  cnt         <= '0;
               end
            end
            S_WR_REQ: begin
               if (axi_grant || timeout_hit) begin
                  state        <= S_WR_RESP;
                  axi_request  <= 1'b0;
                  axi_we       <= 1'b0;
                  s_axil_bresp <= axi_grant ? RESP_OKAY : RESP_SLVERR;
                  aw_held      <= 1'b0;
                  w_held       <= 1'b0;
                  last_wr      <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WR_RESP: begin
               // bvalid rises one cycle after the memory write cycle closes.
               if (!s_axil_bvalid) begin
                  s_axil_bvalid <= 1'b1;
               end else if (s_axil_bready) begin
                  s_axil_bvalid <= 1'b0;
                  state         <= S_IDLE;
               end
            end
            S_RD_REQ: begin
               if (axi_grant) begin
                  state       <= S_RD_WAIT;
                  axi_request <= 1'b0;
               end else if (timeout_hit) begin
                  state         <= S_RD_RESP;
                  axi_request   <= 1'b0;
                  s_axil_rdata  <= '0;
                  s_axil_rresp  <= RESP_SLVERR;
                  s_axil_rvalid <= 1'b1;
                  ar_held       <= 1'b0;
                  last_wr       <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RD_WAIT: begin
               // Memory returns read data the cycle after the granted request.
               state         <= S_RD_RESP;
               s_axil_rdata  <= axi_rdata;
               s_axil_rresp  <= RESP_OKAY;
               s_axil_rvalid <= 1'b1;
               ar_held       <= 1'b0;
               last_wr       <= 1'b0;
            end
            S_RD_RESP: begin
               if (s_axil_rready) begin
                  s_axil_rvalid <= 1'b0;
                  state         <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_share_mem_bridge.sv
// Directed + randomized bench for axil_share_mem_bridge against a word-array reference model.
// Includes a behavioural share_memory stand-in with programmable grant denial.
// Checks are counted per comparison; failures are reported with observed and expected values.
module tb_axil_share_mem_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  s_axil_awaddr;
    logic        s_axil_awvalid, s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid, s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid, s_axil_bready;
    logic [9:0]  s_axil_araddr;
    logic        s_axil_arvalid, s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid, s_axil_rready;
    logic        axi_request, axi_we, axi_grant;
    logic [7:0]  axi_addr;
    logic [31:0] axi_wdata, axi_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axil_share_mem_bridge dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready),
        .axi_request(axi_request), .axi_we(axi_we), .axi_addr(axi_addr), .axi_wdata(axi_wdata),
        .axi_rdata(axi_rdata), .axi_grant(axi_grant)
    );

    // share_memory stand-in: grant withheld for the first deny_n cycles of each request.
    logic [31:0] mem [256];
    logic [31:0] mem_rdata;
    int          deny_n = 0;
    int          req_age = 0;
    assign axi_grant = axi_request && (req_age >= deny_n);
    assign axi_rdata = mem_rdata;
    always @(posedge clk) begin
        if (axi_request && axi_grant) begin
            if (axi_we) mem[axi_addr] <= axi_wdata;
            else        mem_rdata <= mem[axi_addr];
        end
        if (!axi_request)    req_age <= 0;
        else if (!axi_grant) req_age <= req_age + 1;
    end

    // Monitor: request cycles, bvalid cycles, and a log of granted accesses.
    int          req_cnt = 0;
    int          bvalid_cnt = 0;
    logic        g_we[$];
    logic [7:0]  g_addr[$];
    logic [31:0] g_wdata[$];
    always @(negedge clk) begin
        if (axi_request) req_cnt++;
        if (s_axil_bvalid) bvalid_cnt++;
        if (axi_request && axi_grant) begin
            g_we.push_back(axi_we);
            g_addr.push_back(axi_addr);
            g_wdata.push_back(axi_wdata);
        end
    end

    logic [31:0] ref_mem [256];

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic report(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic axil_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_delay, output int hs_edge, output int b_edge,
                           output logic [1:0] resp);
        bit aw_done, w_done;
        int k;
        aw_done = 0; w_done = 0; k = 0;
        hs_edge = -1; b_edge = -1; resp = 2'bxx;
        @(negedge clk);
        s_axil_awaddr = a; s_axil_awvalid = 1'b1;
        while (!(aw_done && w_done) && k < 200) begin
            if (k == w_delay) begin
                s_axil_wdata = d; s_axil_wstrb = s; s_axil_wvalid = 1'b1;
            end
            if (s_axil_awvalid && s_axil_awready) aw_done = 1;
            if (s_axil_wvalid && s_axil_wready) w_done = 1;
            hs_edge = cyc + 1;
            @(negedge clk);
            if (aw_done) s_axil_awvalid = 1'b0;
            if (w_done)  s_axil_wvalid = 1'b0;
            k++;
        end
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        k = 0;
        while (!s_axil_bvalid && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (s_axil_bvalid) begin
            b_edge = cyc; resp = s_axil_bresp;
        end
        @(negedge clk);
    endtask

    task automatic axil_rd(input logic [9:0] a, output int hs_edge, output int r_edge,
                           output logic [1:0] resp, output logic [31:0] data);
        int k;
        k = 0; hs_edge = -1; r_edge = -1; resp = 2'bxx; data = 'x;
        @(negedge clk);
        s_axil_araddr = a; s_axil_arvalid = 1'b1;
        while (!(s_axil_arvalid && s_axil_arready) && k < 200) begin
            @(negedge clk);
            k++;
        end
        hs_edge = cyc + 1;
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        k = 0;
        while (!s_axil_rvalid && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (s_axil_rvalid) begin
            r_edge = cyc; resp = s_axil_rresp; data = s_axil_rdata;
        end
        @(negedge clk);
    endtask

    initial begin
        int hs, be, re, hs2, re2, req0, log0, b0, dn;
        logic [1:0] rsp, rsp2;
        logic [31:0] rd, rd2, d;
        logic [9:0] a;

        rst = 1'b1;
        s_axil_awaddr = '0; s_axil_awvalid = 1'b0;
        s_axil_wdata = '0; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b0;
        s_axil_araddr = '0; s_axil_arvalid = 1'b0;
        s_axil_bready = 1'b1; s_axil_rready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0; ref_mem[i] = 32'h0;
        end
        repeat (3) @(negedge clk);

        // Reset values
        checks++; if (s_axil_awready !== 1'b0) report("rst_awready", s_axil_awready, 1'b0);
        checks++; if (s_axil_wready !== 1'b0) report("rst_wready", s_axil_wready, 1'b0);
        checks++; if (s_axil_arready !== 1'b0) report("rst_arready", s_axil_arready, 1'b0);
        checks++; if (s_axil_bvalid !== 1'b0) report("rst_bvalid", s_axil_bvalid, 1'b0);
        checks++; if (s_axil_rvalid !== 1'b0) report("rst_rvalid", s_axil_rvalid, 1'b0);
        checks++; if (axi_request !== 1'b0) report("rst_request", axi_request, 1'b0);
        checks++; if (axi_we !== 1'b0) report("rst_we", axi_we, 1'b0);
        checks++; if (axi_addr !== 8'h00) report("rst_addr", axi_addr, 8'h00);
        checks++; if (axi_wdata !== 32'h0) report("rst_wdata", axi_wdata, 32'h0);
        checks++; if (s_axil_bresp !== 2'b00) report("rst_bresp", s_axil_bresp, 2'b00);
        checks++; if (s_axil_rresp !== 2'b00) report("rst_rresp", s_axil_rresp, 2'b00);
        checks++; if (s_axil_rdata !== 32'h0) report("rst_rdata", s_axil_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (s_axil_awready !== 1'b1) report("post_rst_awready", s_axil_awready, 1'b1);
        checks++; if (s_axil_arready !== 1'b1) report("post_rst_arready", s_axil_arready, 1'b1);

        // Basic write then read, immediate grant
        req0 = req_cnt; log0 = g_we.size();
        axil_wr(10'h080, 32'hAABBCCDD, 4'hF, 0, hs, be, rsp);
        ref_mem[8'h20] = 32'hAABBCCDD;
        checks++; if (rsp !== 2'b00) report("wr1_bresp", rsp, 2'b00);
        checks++; if (be - hs !== 2) report("wr1_latency", be - hs, 2);
        checks++; if (req_cnt - req0 !== 1) report("wr1_req_cycles", req_cnt - req0, 1);
        checks++; if (g_we.size() - log0 !== 1) report("wr1_grants", g_we.size() - log0, 1);
        checks++; if (g_addr[log0] !== 8'h20) report("wr1_mem_addr", g_addr[log0], 8'h20);
        checks++; if (g_wdata[log0] !== 32'hAABBCCDD) report("wr1_mem_wdata", g_wdata[log0], 32'hAABBCCDD);
        axil_rd(10'h080, hs, re, rsp, rd);
        checks++; if (rsp !== 2'b00) report("rd1_rresp", rsp, 2'b00);
        checks++; if (rd !== 32'hAABBCCDD) report("rd1_rdata", rd, 32'hAABBCCDD);
        checks++; if (re - hs !== 2) report("rd1_latency", re - hs, 2);

        // W arrives 3 cycles after AW: request only once W is held
        req0 = req_cnt;
        axil_wr(10'h084, 32'h12345678, 4'hF, 3, hs, be, rsp);
        ref_mem[8'h21] = 32'h12345678;
        checks++; if (req_cnt - req0 !== 1) report("wdly_req_cycles", req_cnt - req0, 1);
        checks++; if (be - hs !== 2) report("wdly_latency", be - hs, 2);
        checks++; if (rsp !== 2'b00) report("wdly_bresp", rsp, 2'b00);

        // Grant withheld 10 cycles
        deny_n = 10; req0 = req_cnt;
        axil_wr(10'h0C0, 32'hCAFEF00D, 4'hF, 0, hs, be, rsp);
        ref_mem[8'h30] = 32'hCAFEF00D;
        checks++; if (req_cnt - req0 !== 11) report("deny10_req_cycles", req_cnt - req0, 11);
        checks++; if (be - hs !== 12) report("deny10_latency", be - hs, 12);
        checks++; if (rsp !== 2'b00) report("deny10_bresp", rsp, 2'b00);

        // Grant withheld indefinitely: write timeout
        deny_n = 100000; req0 = req_cnt; log0 = g_we.size();
        axil_wr(10'h0C0, 32'h0BADBEEF, 4'hF, 0, hs, be, rsp);
        checks++; if (rsp !== 2'b10) report("wto_bresp", rsp, 2'b10);
        checks++; if (req_cnt - req0 !== 64) report("wto_req_cycles", req_cnt - req0, 64);
        checks++; if (be - hs !== 65) report("wto_latency", be - hs, 65);
        checks++; if (g_we.size() - log0 !== 0) report("wto_no_grant", g_we.size() - log0, 0);
        // Read timeout
        axil_rd(10'h0C0, hs, re, rsp, rd);
        checks++; if (rsp !== 2'b10) report("rto_rresp", rsp, 2'b10);
        checks++; if (rd !== 32'h0) report("rto_rdata", rd, 32'h0);
        checks++; if (re - hs !== 64) report("rto_latency", re - hs, 64);
        deny_n = 0;
        axil_rd(10'h0C0, hs, re, rsp, rd);
        checks++; if (rd !== ref_mem[8'h30]) report("wto_mem_unchanged", rd, ref_mem[8'h30]);

        // Simultaneous write and read: write wins after a read was last served
        log0 = g_we.size();
        fork
            axil_wr(10'h200, 32'h11112222, 4'hF, 0, hs, be, rsp);
            axil_rd(10'h200, hs2, re2, rsp2, rd2);
        join
        ref_mem[8'h80] = 32'h11112222;
        checks++; if (g_we[log0] !== 1'b1) report("pair1_first_is_write", g_we[log0], 1'b1);
        checks++; if (g_we[log0+1] !== 1'b0) report("pair1_second_is_read", g_we[log0+1], 1'b0);
        checks++; if (rd2 !== 32'h11112222) report("pair1_read_sees_write", rd2, 32'h11112222);
        // Lone write makes write the last served, so the next pair goes read first
        axil_wr(10'h204, 32'h33334444, 4'hF, 0, hs, be, rsp);
        ref_mem[8'h81] = 32'h33334444;
        log0 = g_we.size();
        fork
            axil_wr(10'h200, 32'h55556666, 4'hF, 0, hs, be, rsp);
            axil_rd(10'h200, hs2, re2, rsp2, rd2);
        join
        checks++; if (g_we[log0] !== 1'b0) report("pair2_first_is_read", g_we[log0], 1'b0);
        checks++; if (g_we[log0+1] !== 1'b1) report("pair2_second_is_write", g_we[log0+1], 1'b1);
        checks++; if (rd2 !== ref_mem[8'h80]) report("pair2_read_sees_old", rd2, ref_mem[8'h80]);
        ref_mem[8'h80] = 32'h55556666;

        // Partial strobe
        axil_wr(10'h240, 32'h77778888, 4'b0011, 0, hs, be, rsp);
`ifdef AXIL_BRIDGE_STRB_CHECK_EN
        checks++; if (rsp !== 2'b10) report("strb_bresp", rsp, 2'b10);
`else
        checks++; if (rsp !== 2'b00) report("strb_bresp", rsp, 2'b00);
        ref_mem[8'h90] = 32'h77778888;
`endif
        axil_rd(10'h240, hs, re, rsp, rd);
        checks++; if (rd !== ref_mem[8'h90]) report("strb_readback", rd, ref_mem[8'h90]);

        // Reset while waiting for grant in WR_REQ
        deny_n = 100000;
        @(negedge clk);
        s_axil_awaddr = 10'h300; s_axil_awvalid = 1'b1;
        s_axil_wdata = 32'hDEADDEAD; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (axi_request !== 1'b1) report("midrst_req_before", axi_request, 1'b1);
        b0 = bvalid_cnt;
        rst = 1'b1;
        #1;
        checks++; if (axi_request !== 1'b0) report("midrst_req_dropped", axi_request, 1'b0);
        checks++; if (s_axil_awready !== 1'b0) report("midrst_awready", s_axil_awready, 1'b0);
        @(negedge clk);
        rst = 1'b0; deny_n = 0;
        repeat (5) @(negedge clk);
        checks++; if (bvalid_cnt - b0 !== 0) report("midrst_no_bvalid", bvalid_cnt - b0, 0);
        checks++; if (axi_request !== 1'b0) report("midrst_idle_req", axi_request, 1'b0);
        axil_wr(10'h300, 32'h0F0F0F0F, 4'hF, 0, hs, be, rsp);
        ref_mem[8'hC0] = 32'h0F0F0F0F;
        checks++; if (rsp !== 2'b00) report("midrst_next_bresp", rsp, 2'b00);
        checks++; if (be - hs !== 2) report("midrst_next_latency", be - hs, 2);
        axil_rd(10'h300, hs, re, rsp, rd);
        checks++; if (rd !== 32'h0F0F0F0F) report("midrst_readback", rd, 32'h0F0F0F0F);

        // Randomized traffic against the reference word array
        for (int i = 0; i < 40; i++) begin
            a  = 10'h100 + 10'($urandom_range(0, 63));
            d  = $urandom;
            dn = $urandom_range(0, 3);
            deny_n = dn;
            if ($urandom_range(0, 1) == 1) begin
                axil_wr(a, d, 4'hF, $urandom_range(0, 2), hs, be, rsp);
                ref_mem[a[9:2]] = d;
                checks++; if (rsp !== 2'b00) report("rand_wr_bresp", rsp, 2'b00);
                checks++; if (be - hs !== 2 + dn) report("rand_wr_latency", be - hs, 2 + dn);
            end else begin
                axil_rd(a, hs, re, rsp, rd);
                checks++; if (rd !== ref_mem[a[9:2]]) report("rand_rd_rdata", rd, ref_mem[a[9:2]]);
                checks++; if (re - hs !== 2 + dn) report("rand_rd_latency", re - hs, 2 + dn);
            end
        end
        deny_n = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
